clks_alot_driver: RTL and testbench
===================================

Name: clks_alot_driver

Overview:
Clock transmitter that is the counterpart to the sir_clks_alot recovery path. It synthesises an IO clock from the system clock with programmable high/low half-periods and drives it single-ended or as a differential pair. It supports glitch-free pause/resume at a chosen idle level. It reports its own state as a clock_state_s so that generator and recoverer expose the same status view.

Parameters:
COUNTER_WIDTH, 32 (clks_alot_p::COUNTER_WIDTH), width of the half-period and pause-duration counters.
DIFFERENTIAL, 1, 1 = io_pins_o.neg driven as the complement of pos; 0 = neg held 0.

Ports:
clk_i  in  1  system clock; the only clock
rst_n_i  in  1  reset, synchronous, active-low
enable_i  in  1  run request
cfg_valid_i  in  1  new half-period config offered
cfg_ready_o  out  1  config accepted when valid and ready are both high
cfg_high_i  in  COUNTER_WIDTH  high half-period in clk_i cycles
cfg_low_i  in  COUNTER_WIDTH  low half-period in clk_i cycles
pause_req_i  in  1  level; high = pause requested
pause_level_i  in  1  idle level to park at; sampled when a pause is accepted
io_pins_o  out  recovery_pins_s  driven clock pins
state_o  out  clock_state_s  clk, pause_active, pause_duration, locked, events

Behaviour:
- Reset, applied synchronously while rst_n_i=0, takes effect at the next clk_i edge:
  - state IDLE; active config high=1, low=1
  - io_pins_o pos=0, neg=DIFFERENTIAL
  - state_o all 0 except events.steady_low=1
  - cfg_ready_o=1
- FSM states: IDLE, HIGH, LOW, PAUSED. All outputs are registered.
- IDLE:
  - Clock held low.
  - enable_i=1 and pause_req_i=0 → HIGH, so the rising edge appears on the next registered cycle.
- HIGH:
  - The counter loads high-1 on entry; the phase lasts exactly `high` cycles.
  - At terminal count, the next state is chosen in priority order:
    1. PAUSED, if pause_req_i=1 and pause_level_i=0
    2. IDLE, if enable_i=0
    3. LOW otherwise
- LOW:
  - Lasts exactly `low` cycles. Period = high + low.
  - At terminal count, the next state is chosen in priority order:
    1. IDLE, if enable_i=0
    2. PAUSED, if pause_req_i=1 and pause_level_i=1
    3. HIGH otherwise
- Pause to the opposite level: a pause requested at level 1 during HIGH first completes HIGH and LOW, then parks. Any park occurs only at a phase boundary, so no half-phase is ever shorter than programmed.
- PAUSED:
  - The clock holds the parked level and pause_active=1.
  - pause_duration is set to 1 on entry, increments each cycle, and saturates at all-ones. It holds its value after exit until the next entry.
  - When pause_req_i=0:
    - parked at 0 → HIGH
    - parked at 1 → LOW
  - When enable_i=0: parked at 0 → IDLE; parked at 1 → LOW for a full low phase, then IDLE.
- Config:
  - cfg_ready_o=1 in IDLE, in PAUSED, and in the LOW terminal-count cycle; 0 otherwise.
  - An accepted config takes effect from the next phase entered.
  - A value of 0 is clamped to 1, so the minimum period is 2 cycles.
- Lock:
  - locked is set on the LOW→HIGH transition that completes the first full high+low period since the last clear.
  - locked is cleared on config accept, on entry to PAUSED, and on entry to IDLE.
- Events:
  - Derived from the registered clk versus its previous value; exactly one event is asserted per cycle.
  - rising_edge / falling_edge are single-cycle pulses. steady_high / steady_low cover all other cycles.
- Simultaneous conditions:
  - cfg accept and pause entry in the same cycle: the cfg is applied and locked=0.
  - pause_req_i deasserted before the park boundary: the pause is cancelled with no effect.
- Reset mid-phase: immediate return to reset values; the pins may truncate the phase (accepted).

Optional Feature:
CLKS_ALOT_DRIVER_SKEW_EN
- When defined:
  - Adds input skew_i [3:0].
  - neg is the complement of pos delayed by skew_i cycles (shift register, depth 15).
  - Used to provoke diff_rising/falling_edge_violation in the recoverer.
  - skew_i is sampled at config accept.
- When undefined:
  - The port is absent.
  - neg is the complement of pos in the same cycle.

Decomposition:
- Reuse clks_alot_p for recovery_pins_s, generated_events_s and clock_state_s.
- Add to clks_alot_p: driver_state_e {IDLE, HIGH, LOW, PAUSED} and the cfg struct clk_driver_cfg_s {high, low}.
- One sub-module: clks_alot_phase_counter, a loadable down-counter with a terminal-count flag and zero-clamp.

Test Plan:
- high=3, low=2, enable after reset: pos pattern 11100 repeating; first rise 1 cycle after enable; locked at the first LOW→HIGH (cycle 6).
- Config 0/0: period 2 (10 repeating); cfg_ready_o pulses only in LOW terminal-count cycles.
- pause_level=0 requested mid-HIGH of a 4/4 clock: high completes 4 cycles, pos parks 0, pause_active=1; after 10 paused cycles pause_duration=10; release gives a rise the next cycle and locked=0 until a full period completes.
- pause_level=1 requested during HIGH: full HIGH+LOW, then parks at 1; release enters LOW, so the first event is falling_edge.
- enable_i dropped mid-HIGH of 5/5: HIGH finishes its 5 cycles, then IDLE with pos=0; no truncated phases.
- SKEW_EN with skew=2 and DIFFERENTIAL=1: neg edges lag pos edges by 2 cycles; with skew=0, neg is the complement of pos on every cycle.

Source files
------------

// File: rtl/clks_alot_p.sv
// clks_alot_p: shared pin, event and status types for the clks_alot generator and recoverer
package clks_alot_p;

    localparam int COUNTER_WIDTH = 32;

    typedef struct packed {
        logic pos;
        logic neg;
    } recovery_pins_s;

    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
        logic steady_high;
        logic steady_low;
    } generated_events_s;

    typedef struct packed {
        logic                     clk;
        logic                     pause_active;
        logic [COUNTER_WIDTH-1:0] pause_duration;
        logic                     locked;
        generated_events_s        events;
    } clock_state_s;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, PAUSED} driver_state_e;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] high;
        logic [COUNTER_WIDTH-1:0] low;
    } clk_driver_cfg_s;

    function automatic logic [COUNTER_WIDTH-1:0] clamp_period(input logic [COUNTER_WIDTH-1:0] v);
        return (v == '0) ? COUNTER_WIDTH'(1) : v;
    endfunction

endpackage

// File: rtl/clks_alot_phase_counter.sv
// clks_alot_phase_counter: loadable down-counter timing one clock half-phase; a zero length counts as one
module clks_alot_phase_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] len_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    // load len-1 on phase entry, then count down to the terminal cycle and hold there
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= (len_i == '0) ? '0 : len_i - WIDTH'(1);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - WIDTH'(1);
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/clks_alot_driver.sv
// clks_alot_driver: programmable IO clock generator with glitch-free pause; CLKS_ALOT_DRIVER_SKEW_EN adds skew_i to delay neg
module clks_alot_driver #(
    parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
    parameter bit DIFFERENTIAL  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       enable_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [COUNTER_WIDTH-1:0]   cfg_high_i,
    input  logic [COUNTER_WIDTH-1:0]   cfg_low_i,
    input  logic                       pause_req_i,
    input  logic                       pause_level_i,
`ifdef CLKS_ALOT_DRIVER_SKEW_EN
    input  logic [3:0]                 skew_i,
`endif
    output clks_alot_p::recovery_pins_s io_pins_o,
    output clks_alot_p::clock_state_s   state_o
);

    import clks_alot_p::*;

    localparam int CW = clks_alot_p::COUNTER_WIDTH;

    driver_state_e      st_q, st_n;
    clk_driver_cfg_s    cfg_q, cfg_n;
    generated_events_s  events_q;
    logic [COUNTER_WIDTH-1:0] pause_cnt_q, load_len;
    logic tc, accept, load, clr, park_q, park_n, pos_q, pos_n, neg_q, neg_src;
    logic had_high_q, locked_q;

    clks_alot_phase_counter #(.WIDTH(COUNTER_WIDTH)) u_phase (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (load),
        .len_i   (load_len),
        .tc_o    (tc)
    );

    // next state: phases only end on their terminal cycle, so no half-phase is ever cut short
    always_comb begin
        st_n = st_q;
        case (st_q)
            IDLE:    st_n = (enable_i && !pause_req_i) ? HIGH : IDLE;
            HIGH:    st_n = !tc ? HIGH : (pause_req_i && !pause_level_i) ? PAUSED : !enable_i ? IDLE : LOW;
            LOW:     st_n = !tc ? LOW : !enable_i ? IDLE : (pause_req_i && pause_level_i) ? PAUSED : HIGH;
            PAUSED:  st_n = !enable_i ? (park_q ? LOW : IDLE) : !pause_req_i ? (park_q ? LOW : HIGH) : PAUSED;
            default: st_n = IDLE;
        endcase
    end

    assign cfg_ready_o = (st_q == IDLE) || (st_q == PAUSED) || (st_q == LOW && tc);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign cfg_n       = accept ? clk_driver_cfg_s'{high: clamp_period(CW'(cfg_high_i)), low: clamp_period(CW'(cfg_low_i))} : cfg_q;
    assign load        = (st_n != st_q) && (st_n == HIGH || st_n == LOW);
    assign load_len    = COUNTER_WIDTH'((st_n == HIGH) ? cfg_n.high : cfg_n.low);
    assign park_n      = (st_n == PAUSED && st_q != PAUSED) ? pause_level_i : park_q;
    assign pos_n       = (st_n == HIGH) || (st_n == PAUSED && park_n);
    assign clr         = accept || ((st_n != st_q) && (st_n == PAUSED || st_n == IDLE));

`ifdef CLKS_ALOT_DRIVER_SKEW_EN
    logic [3:0]  skew_q;
    logic [13:0] hist_q;
    logic [15:0] taps;
    assign taps    = {hist_q, pos_q, pos_n};
    assign neg_src = taps[skew_q];
    // pos history for the skewed complement; skew only changes when a config is accepted
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            skew_q <= '0;
            hist_q <= '0;
        end else begin
            if (accept)
                skew_q <= skew_i;
            hist_q <= {hist_q[12:0], pos_q};
        end
    end
`else
    assign neg_src = pos_n;
`endif

    // state, config, pins and events all registered together so every output is a flop
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q     <= IDLE;
            cfg_q    <= clk_driver_cfg_s'{high: CW'(1), low: CW'(1)};
            park_q   <= 1'b0;
            pos_q    <= 1'b0;
            neg_q    <= DIFFERENTIAL;
            events_q <= generated_events_s'{rising_edge: 1'b0, falling_edge: 1'b0, steady_high: 1'b0, steady_low: 1'b1};
        end else begin
            st_q     <= st_n;
            cfg_q    <= cfg_n;
            park_q   <= park_n;
            pos_q    <= pos_n;
            neg_q    <= DIFFERENTIAL ? ~neg_src : 1'b0;
            events_q <= generated_events_s'{rising_edge: pos_n & ~pos_q, falling_edge: ~pos_n & pos_q,
                                            steady_high: pos_n & pos_q, steady_low: ~pos_n & ~pos_q};
        end
    end

    // lock needs a full high phase followed by a full low phase since the last clear
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr) begin
            had_high_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            if (st_q == HIGH && st_n == LOW)
                had_high_q <= 1'b1;
            if (st_q == LOW && st_n == HIGH && had_high_q)
                locked_q <= 1'b1;
        end
    end

    // pause duration restarts at 1 on entry, saturates, and holds after exit
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            pause_cnt_q <= '0;
        else if (st_n == PAUSED)
            pause_cnt_q <= (st_q != PAUSED) ? COUNTER_WIDTH'(1) : (&pause_cnt_q) ? pause_cnt_q : pause_cnt_q + COUNTER_WIDTH'(1);
    end

    assign io_pins_o = recovery_pins_s'{pos: pos_q, neg: neg_q};
    assign state_o   = clock_state_s'{clk: pos_q, pause_active: (st_q == PAUSED), pause_duration: CW'(pause_cnt_q),
                                      locked: locked_q, events: events_q};

endmodule

// File: tb/tb_clks_alot_driver.sv
// tb_clks_alot_driver: randomized and directed scenarios checked against an arithmetic waveform model
module tb_clks_alot_driver;

    localparam int W = clks_alot_p::COUNTER_WIDTH;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0, pause_req = 1'b0, pause_level = 1'b0;
    logic cfg_ready;
    logic [W-1:0] cfg_high = '0, cfg_low = '0;
    clks_alot_p::recovery_pins_s pins;
    clks_alot_p::clock_state_s   st;
    int errors = 0, checks = 0;
`ifdef CLKS_ALOT_DRIVER_SKEW_EN
    logic [3:0] skew = 4'd0;
`endif

    always #5 clk = ~clk;

    clks_alot_driver dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .enable_i      (enable),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_high_i    (cfg_high),
        .cfg_low_i     (cfg_low),
        .pause_req_i   (pause_req),
        .pause_level_i (pause_level),
`ifdef CLKS_ALOT_DRIVER_SKEW_EN
        .skew_i        (skew),
`endif
        .io_pins_o     (pins),
        .state_o       (st)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // event expected from the clock level now versus one cycle earlier: {rise, fall, steady_high, steady_low}
    function automatic logic [3:0] ev(input logic prev, input logic cur);
        return {cur & ~prev, ~cur & prev, cur & prev, ~cur & ~prev};
    endfunction

    task automatic load_cfg(input int h, input int l);
        cfg_high = W'(h);
        cfg_low = W'(l);
        cfg_valid = 1'b1;
        step;
        cfg_valid = 1'b0;
    endtask

    task automatic go_idle;
        enable = 1'b0;
        pause_req = 1'b0;
        pause_level = 1'b0;
        repeat (30) step;
    endtask

    task automatic test_reset(input string name);
        rst_n = 1'b0;
        repeat (2) step;
        checks++;
        if ({pins, cfg_ready, st} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL %s got pins=%b ready=%b state=%h", name, pins, cfg_ready, st);
        end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_free_run(input int h, input int l, input int periods);
        int eh, el, p;
        logic ep, prev;
        logic [9:0] got, exp;
        eh = (h == 0) ? 1 : h;
        el = (l == 0) ? 1 : l;
        p = eh + el;
        load_cfg(h, l);
        enable = 1'b1;
        prev = 1'b0;
        for (int t = 1; t <= periods * p; t++) begin
            step;
            ep = ((t - 1) % p) < eh;
            got = {pins.pos, pins.neg, st.clk, cfg_ready, st.locked, st.pause_active, st.events};
            exp = {ep, ~ep, ep, ((t - 1) % p) == p - 1, t > p, 1'b0, ev(prev, ep)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL free_run h=%0d l=%0d t=%0d got=%b exp=%b", h, l, t, got, exp);
            end
            prev = ep;
        end
        go_idle;
        checks++;
        if ({pins.pos, cfg_ready, st.locked, st.pause_active} !== 4'b0100) begin
            errors++;
            $display("FAIL free_run_idle got pos/ready/locked/pause=%b exp=0100", {pins.pos, cfg_ready, st.locked, st.pause_active});
        end
    endtask

    task automatic test_pause_low;
        logic ep, prev, epa, erdy;
        logic [9:0] got, exp;
        load_cfg(4, 4);
        enable = 1'b1;
        prev = 1'b0;
        for (int t = 1; t <= 23; t++) begin
            step;
            ep = (t <= 4) || (t >= 15 && t <= 18) || t == 23;
            epa = (t >= 5 && t <= 14);
            erdy = epa || t == 22;
            got = {pins.pos, pins.neg, st.clk, cfg_ready, st.locked, st.pause_active, st.events};
            exp = {ep, ~ep, ep, erdy, t == 23, epa, ev(prev, ep)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pause_low t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t >= 5) begin
                checks++;
                if (st.pause_duration !== W'((t <= 14) ? t - 4 : 10)) begin
                    errors++;
                    $display("FAIL pause_low_duration t=%0d got=%0d exp=%0d", t, st.pause_duration, (t <= 14) ? t - 4 : 10);
                end
            end
            prev = ep;
            if (t == 2) begin
                pause_req = 1'b1;
                pause_level = 1'b0;
            end
            if (t == 9) pause_level = 1'b1;
            if (t == 14) pause_req = 1'b0;
        end
        go_idle;
    endtask

    task automatic test_pause_high;
        int n;
        logic ep, prev, epa, erdy;
        logic [9:0] got, exp;
        n = int'($urandom_range(2, 8));
        load_cfg(3, 3);
        enable = 1'b1;
        prev = 1'b0;
        for (int t = 1; t <= 16 + n; t++) begin
            step;
            epa = (t >= 7 && t <= 6 + n);
            ep = (t <= 3) || epa || (t >= 10 + n && t <= 12 + n) || t == 16 + n;
            erdy = epa || t == 6 || t == 9 + n || t == 15 + n;
            got = {pins.pos, pins.neg, st.clk, cfg_ready, st.locked, st.pause_active, st.events};
            exp = {ep, ~ep, ep, erdy, t == 16 + n, epa, ev(prev, ep)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pause_high n=%0d t=%0d got=%b exp=%b", n, t, got, exp);
            end
            prev = ep;
            if (t == 1) begin
                pause_req = 1'b1;
                pause_level = 1'b1;
            end
            if (t == 6 + n) begin
                pause_req = 1'b0;
                pause_level = 1'b0;
            end
        end
        go_idle;
    endtask

    task automatic test_enable_drop;
        logic ep;
        logic [3:0] got, exp;
        load_cfg(5, 5);
        enable = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            step;
            ep = (t <= 5);
            got = {pins.pos, pins.neg, cfg_ready, st.locked};
            exp = {ep, ~ep, t >= 6, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL enable_drop t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 2) enable = 1'b0;
        end
        go_idle;
    endtask

    task automatic test_cancel;
        logic ep;
        logic [4:0] got, exp;
        load_cfg(4, 4);
        enable = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            step;
            ep = ((t - 1) % 8) < 4;
            got = {pins.pos, pins.neg, cfg_ready, st.locked, st.pause_active};
            exp = {ep, ~ep, ((t - 1) % 8) == 7, t > 8, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cancel t=%0d got=%b exp=%b", t, got, exp);
            end
            pause_req = (t == 1);
        end
        go_idle;
    endtask

    task automatic test_cfg_midrun;
        logic ep;
        logic [3:0] got, exp;
        load_cfg(2, 2);
        enable = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            step;
            ep = (t <= 2) || (t >= 5 && t <= 7) || (t >= 9 && t <= 11) || t == 13;
            got = {pins.pos, pins.neg, cfg_ready, st.locked};
            exp = {ep, ~ep, t == 4 || t == 8 || t == 12, t >= 9};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cfg_midrun t=%0d got=%b exp=%b", t, got, exp);
            end
            if (t == 1) begin
                cfg_high = W'(3);
                cfg_low = W'(1);
                cfg_valid = 1'b1;
            end
            if (t == 5) cfg_valid = 1'b0;
        end
        go_idle;
    endtask

    task automatic test_reset_midrun;
        load_cfg(3, 3);
        enable = 1'b1;
        repeat (2) step;
        test_reset("reset_midrun");
        enable = 1'b0;
        step;
    endtask

`ifdef CLKS_ALOT_DRIVER_SKEW_EN
    function automatic logic pos_at(input int k);
        return (k <= 0) ? 1'b0 : (((k - 1) % 6) < 3);
    endfunction

    task automatic test_skew(input int s);
        logic [1:0] got, exp;
        skew = 4'(s);
        load_cfg(3, 3);
        enable = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step;
            got = {pins.pos, pins.neg};
            exp = {pos_at(t), ~pos_at(t - s)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL skew s=%0d t=%0d got=%b exp=%b", s, t, got, exp);
            end
        end
        go_idle;
    endtask
`endif

    initial begin
        test_reset("reset");
        test_free_run(3, 2, 3);
        test_free_run(0, 0, 4);
        for (int i = 0; i < 4; i++)
            test_free_run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 3);
        test_pause_low;
        test_pause_high;
        test_enable_drop;
        test_cancel;
        test_cfg_midrun;
        test_reset_midrun;
`ifdef CLKS_ALOT_DRIVER_SKEW_EN
        test_skew(2);
        test_skew(0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
